// File: rtl/dbg_emio_probe.sv
// EMIO/GPIO debug probe: GPIO-driven fake stream handshakes, probe readback, snapshot, beat/packet counters.
// Define DBG_EMIO_PROBE_SYNC_EN to insert a 2-flop synchroniser ahead of the from_gpio register stage.
`timescale 1ns/1ps
module dbg_emio_probe #(
  parameter int NUM_CH  = 8,
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 4,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [63:0]                from_gpio,
  output logic [63:0]                to_gpio,
  output logic                       fake_out_valid,
  output logic                       fake_out_ready,
  output logic                       fake_out_last,
  input  logic                       out_busy,
  input  logic [NUM_CH*DATA_W-1:0]   probe_data,
  input  logic                       mon_valid,
  input  logic                       mon_ready,
  input  logic                       mon_last
);

  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    LIVE = 2'd0,
    WAIT = 2'd1,
    HELD = 2'd2
  } state_t;

  logic [63:0] g_in;
  logic [63:0] g_q;
  logic [3:0]  prev_q;

`ifdef DBG_EMIO_PROBE_SYNC_EN
  logic [63:0] sync1_q, sync2_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= from_gpio;
      sync2_q <= sync1_q;
    end
  end

  assign g_in = sync2_q;
`else
  assign g_in = from_gpio;
`endif

  // prev_q holds the previous g value of the edge-detected bits {12,11,10,8}
  always_ff @(posedge clk) begin
    if (reset) begin
      g_q    <= '0;
      prev_q <= '0;
    end else begin
      g_q    <= g_in;
      prev_q <= {g_q[12], g_q[11], g_q[10], g_q[8]};
    end
  end

  logic unused_g;
  assign unused_g = ^g_q;

  logic valid_edge, last_edge, snap_edge, clr_edge;
  assign valid_edge = g_q[8]  & ~prev_q[0];
  assign last_edge  = g_q[10] & ~prev_q[1];
  assign snap_edge  = g_q[11] & ~prev_q[2];
  assign clr_edge   = g_q[12] & ~prev_q[3];

  assign fake_out_ready = g_q[9];
  assign fake_out_valid = g_q[13] ? valid_edge : g_q[8];
  assign fake_out_last  = last_edge;

  state_t                     state_q;
  logic                       held_q, wait_q, tflag_q;
  logic [TMR_W-1:0]           timer_q;
  logic [NUM_CH*DATA_W-1:0]   snap_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= LIVE;
      held_q  <= 1'b0;
      wait_q  <= 1'b0;
      tflag_q <= 1'b0;
      timer_q <= '0;
      snap_q  <= '0;
    end else begin
      case (state_q)
        LIVE: begin
          if (snap_edge) begin
            state_q <= WAIT;
            wait_q  <= 1'b1;
            timer_q <= '0;
            tflag_q <= 1'b0;
          end
        end
        WAIT: begin
          // capture on the first quiet cycle, or give up waiting at the timer limit
          if (!out_busy || (timer_q == TMR_LAST)) begin
            snap_q  <= probe_data;
            state_q <= HELD;
            wait_q  <= 1'b0;
            held_q  <= 1'b1;
            if (out_busy) tflag_q <= 1'b1;
          end else begin
            timer_q <= timer_q + TMR_W'(1);
          end
        end
        HELD: begin
          if (snap_edge) begin
            state_q <= LIVE;
            held_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= LIVE;
          held_q  <= 1'b0;
          wait_q  <= 1'b0;
        end
      endcase
    end
  end

  logic [CNT_W-1:0] beat_q, beat_d, pkt_q, pkt_d;
  logic             beat;

  assign beat = mon_valid & mon_ready;

  always_comb begin
    beat_d = beat_q;
    pkt_d  = pkt_q;
    if (clr_edge) begin
      beat_d = '0;
      pkt_d  = '0;
    end else if (beat) begin
      if (beat_q != '1) beat_d = beat_q + CNT_W'(1);
      if (mon_last && (pkt_q != '1)) pkt_d = pkt_q + CNT_W'(1);
    end
  end

  logic [ADDR_W-1:0] addr;
  logic [31:0]       rd_d, rd_q;
  logic              busy_q;

  assign addr = g_q[ADDR_W-1:0];

  always_comb begin
    rd_d = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (addr == ADDR_W'(k)) begin
        rd_d = 32'((state_q == HELD) ? snap_q[k*DATA_W +: DATA_W]
                                     : probe_data[k*DATA_W +: DATA_W]);
      end
    end
    if (addr == ADDR_W'(NUM_CH))     rd_d = 32'(beat_q);
    if (addr == ADDR_W'(NUM_CH + 1)) rd_d = 32'(pkt_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      beat_q <= '0;
      pkt_q  <= '0;
      rd_q   <= '0;
      busy_q <= 1'b0;
    end else begin
      beat_q <= beat_d;
      pkt_q  <= pkt_d;
      rd_q   <= rd_d;
      busy_q <= out_busy;
    end
  end

  assign to_gpio = {28'd0, tflag_q, wait_q, held_q, busy_q, rd_q};

endmodule

// File: tb/tb_dbg_emio_probe.sv
// Scoreboard bench for dbg_emio_probe: stimulus queues expected outputs per cycle, a negedge monitor compares them.
`timescale 1ns/1ps
module tb_dbg_emio_probe;
  localparam int NUM_CH  = 8;
  localparam int DATA_W  = 8;
  localparam int ADDR_W  = 4;
  localparam int CNT_W   = 4;
  localparam int TIMEOUT = 16;
`ifdef DBG_EMIO_PROBE_SYNC_EN
  localparam int L = 3;
`else
  localparam int L = 1;
`endif

  localparam logic [66:0] M_ALL   = {67{1'b1}};
  localparam logic [66:0] M_RD    = {35'd0, 32'hFFFF_FFFF};
  localparam logic [66:0] M_BUSY  = 67'(1) << 32;
  localparam logic [66:0] M_HELD  = 67'(1) << 33;
  localparam logic [66:0] M_WAIT  = 67'(1) << 34;
  localparam logic [66:0] M_TOUT  = 67'(1) << 35;
  localparam logic [66:0] M_VALID = 67'(1) << 64;
  localparam logic [66:0] M_READY = 67'(1) << 65;
  localparam logic [66:0] M_LAST  = 67'(1) << 66;
  localparam logic [66:0] M_ST    = M_WAIT | M_HELD | M_TOUT;

  logic                     clk, reset;
  logic [63:0]              from_gpio, to_gpio;
  logic                     fake_out_valid, fake_out_ready, fake_out_last;
  logic                     out_busy;
  logic [NUM_CH*DATA_W-1:0] probe_data;
  logic                     mon_valid, mon_ready, mon_last;

  dbg_emio_probe #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .from_gpio(from_gpio), .to_gpio(to_gpio),
    .fake_out_valid(fake_out_valid), .fake_out_ready(fake_out_ready), .fake_out_last(fake_out_last),
    .out_busy(out_busy), .probe_data(probe_data),
    .mon_valid(mon_valid), .mon_ready(mon_ready), .mon_last(mon_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [66:0] mask;
    logic [66:0] val;
    logic [95:0] name;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic        done = 1'b0;
  logic [66:0] obs;

  assign obs = {fake_out_last, fake_out_ready, fake_out_valid, to_gpio};

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        checks++;
        if ((obs & sb[i].mask) !== (sb[i].val & sb[i].mask)) begin
          errors++;
          $display("FAIL %0s cyc=%0d got=%h exp=%h mask=%h", sb[i].name, cyc,
                   obs & sb[i].mask, sb[i].val & sb[i].mask, sb[i].mask);
        end
        sb.delete(i);
      end
    end
    if (done) begin
      while (sb.size() > 0) begin
        errors++;
        $display("FAIL %0s never_compared due=%0d now=%0d", sb[0].name, sb[0].due, cyc);
        void'(sb.pop_front());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic exp_at(input int off, input logic [66:0] m, input logic [66:0] v, input logic [95:0] nm);
    exp_t e;
    e.due  = cyc + off;
    e.mask = m;
    e.val  = v;
    e.name = nm;
    sb.push_back(e);
  endtask

  function automatic logic [66:0] rdv(input logic [31:0] x);
    return {35'd0, x};
  endfunction

  task automatic set_probes(input logic [7:0] base);
    for (int k = 0; k < NUM_CH; k++) probe_data[k*DATA_W +: DATA_W] = base + 8'(k);
  endtask

  initial begin
    logic [31:0] e;
    reset = 1'b1; from_gpio = 64'h400; out_busy = 1'b0;
    mon_valid = 1'b0; mon_ready = 1'b0; mon_last = 1'b0; probe_data = '0;
    step(3);
    reset = 1'b0;
    exp_at(0, M_ALL, '0, "rst_all0");
    exp_at(L, M_LAST, M_LAST, "rst_edge");
    exp_at(L + 1, M_LAST, '0, "rst_edge_end");
    step(1);
    from_gpio = '0;
    step(L + 2);

    // readback address sweep
    set_probes(8'h10);
    probe_data[3*DATA_W +: DATA_W] = 8'hA5;
    for (int a = 0; a < 16; a++) begin
      from_gpio = 64'(a);
      if (a == 3)      e = 32'hA5;
      else if (a < 8)  e = 32'h10 + 32'(a);
      else             e = 32'h0;
      exp_at(L + 1, M_RD, rdv(e), "rd_addr");
      step(1);
    end
    step(L + 2);

    // last pulse: held high, then three short toggles
    from_gpio = 64'h400;
    for (int o = 0; o < 20; o++) exp_at(L + o, M_LAST, (o == 0) ? M_LAST : '0, "last_hold");
    step(20);
    from_gpio = '0;
    step(L + 2);
    for (int t = 0; t < 3; t++) begin
      from_gpio = 64'h400;
      exp_at(L, M_LAST, M_LAST, "last_tog");
      exp_at(L + 1, M_LAST, '0, "last_tog_end");
      exp_at(L + 2, M_LAST, '0, "last_tog_end");
      step(1);
      from_gpio = '0;
      step(2);
    end
    step(L + 1);

    // valid: pulse mode, then level mode
    from_gpio = (64'(1) << 13) | (64'(1) << 8) | (64'(1) << 9);
    for (int o = 0; o < 6; o++)
      exp_at(L + o, M_VALID | M_READY, ((o == 0) ? M_VALID : '0) | M_READY, "vld_pulse");
    step(6);
    from_gpio = (64'(1) << 8) | (64'(1) << 9);
    for (int o = 0; o < 4; o++) exp_at(L + o, M_VALID | M_READY, M_VALID | M_READY, "vld_level");
    step(4);
    from_gpio = '0;
    exp_at(L, M_VALID | M_READY, '0, "vld_drop");
    step(L + 2);

    // snapshot with busy dropping after five waiting cycles
    set_probes(8'h20);
    from_gpio = 64'd2;
    out_busy = 1'b1;
    exp_at(1, M_BUSY, M_BUSY, "busy_reg");
    step(L + 2);
    from_gpio = 64'd2 | (64'(1) << 11);
    for (int r = 1; r <= L + 7; r++)
      exp_at(r, M_ST, ((r >= L + 1 && r <= L + 5) ? M_WAIT : '0) | ((r >= L + 6) ? M_HELD : '0), "snap_st");
    step(1);
    from_gpio = 64'd2;
    step(L + 4);
    out_busy = 1'b0;
    step(3);
    set_probes(8'h40);
    for (int a = 0; a < 8; a++) begin
      from_gpio = 64'(a);
      exp_at(L + 1, M_RD | M_HELD, rdv(32'h20 + 32'(a)) | M_HELD, "frozen");
      step(1);
    end
    step(L + 1);
    from_gpio = 64'd2 | (64'(1) << 11);
    exp_at(L + 1, M_HELD | M_WAIT, '0, "release");
    exp_at(L + 1, M_RD, rdv(32'h22), "rel_last_snap");
    exp_at(L + 2, M_RD, rdv(32'h42), "live_rd");
    step(1);
    from_gpio = 64'd2;
    step(L + 3);

    // timeout with busy stuck high; extra snap edge during WAIT is ignored
    out_busy = 1'b1;
    from_gpio = '0;
    step(2);
    from_gpio = 64'(1) << 11;
    for (int r = 1; r <= L + 18; r++)
      exp_at(r, M_ST, ((r >= L + 1 && r <= L + 16) ? M_WAIT : '0) |
                      ((r >= L + 17) ? (M_HELD | M_TOUT) : '0), "tmo_st");
    step(1);
    from_gpio = '0;
    step(3);
    from_gpio = 64'(1) << 11;
    step(1);
    from_gpio = '0;
    step(L + 14);
    from_gpio = 64'(1) << 11;
    exp_at(L + 1, M_ST, M_TOUT, "tmo_rel");
    step(1);
    from_gpio = '0;
    step(L + 2);
    from_gpio = 64'(1) << 11;
    exp_at(L, M_ST, M_TOUT, "tmo_keep");
    exp_at(L + 1, M_ST, M_WAIT, "tmo_clr");
    step(1);
    from_gpio = '0;
    step(L + 1);
    out_busy = 1'b0;
    exp_at(1, M_ST, M_HELD, "cap_nobusy");
    step(2);
    from_gpio = 64'(1) << 11;
    exp_at(L + 1, M_HELD | M_WAIT, '0, "rel2");
    step(1);
    from_gpio = '0;
    step(L + 2);

    // counters: 20 beats, 3 packets, 4 stalled cycles (one with last)
    for (int i = 0; i < 24; i++) begin
      mon_valid = 1'b1;
      mon_ready = (i % 6) != 5;
      mon_last  = (i == 2) || (i == 9) || (i == 15) || (i == 17);
      step(1);
    end
    mon_valid = 1'b0; mon_ready = 1'b0; mon_last = 1'b0;
    step(1);
    from_gpio = 64'd8;
    exp_at(L + 1, M_RD, rdv(32'd15), "beat_sat");
    step(1);
    from_gpio = 64'd9;
    exp_at(L + 1, M_RD, rdv(32'd3), "pkt_cnt");
    step(L + 2);

    // clear edge in the same cycle as a beat: clear wins
    from_gpio = 64'd9 | (64'(1) << 12);
    step(L);
    mon_valid = 1'b1; mon_ready = 1'b1; mon_last = 1'b1;
    step(1);
    mon_valid = 1'b0; mon_ready = 1'b0; mon_last = 1'b0;
    from_gpio = 64'd8;
    exp_at(L + 1, M_RD, rdv(32'd0), "clr_beat");
    step(1);
    from_gpio = 64'd9;
    exp_at(L + 1, M_RD, rdv(32'd0), "clr_pkt");
    step(L + 2);
    mon_valid = 1'b1; mon_ready = 1'b1; mon_last = 1'b1;
    step(1);
    mon_valid = 1'b0; mon_ready = 1'b0; mon_last = 1'b0;
    from_gpio = 64'd8;
    exp_at(L + 1, M_RD, rdv(32'd1), "post_clr_b");
    step(1);
    from_gpio = 64'd9;
    exp_at(L + 1, M_RD, rdv(32'd1), "post_clr_p");
    step(L + 2);

    // reset in the middle of WAIT
    out_busy = 1'b1;
    from_gpio = 64'd8 | (64'(1) << 11);
    exp_at(L + 2, M_WAIT, M_WAIT, "pre_rst_wait");
    step(L + 2);
    reset = 1'b1;
    from_gpio = '0;
    exp_at(1, M_ALL, '0, "rst_mid");
    step(1);
    reset = 1'b0;
    out_busy = 1'b0;
    from_gpio = 64'd8;
    exp_at(L + 1, M_RD | M_WAIT | M_HELD, '0, "rst_cnt");
    step(L + 3);

    done = 1'b1;
    step(2);
  end

endmodule
